// File: rtl/viterbi_pkg.sv
// Shared defaults, FSM encoding and the branch-label helper for the ACS trellis unit.
package viterbi_pkg;

  localparam int         K_DEF    = 3;
  localparam int         BM_W_DEF = 2;
  localparam int         PM_W_DEF = 8;
  localparam int         NACS_DEF = 2;
  localparam logic [2:0] G0_DEF   = 3'b111;
  localparam logic [2:0] G1_DEF   = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACS  = 2'd1,
    ST_OUT  = 2'd2
  } fsm_state_e;

  // Expected encoder output {c0,c1} for the register contents {u,p}.
  // Arguments are zero-extended so any constraint length up to 32 fits.
  function automatic logic [1:0] exp_sym(input logic [31:0] path,
                                         input logic [31:0] g0,
                                         input logic [31:0] g1);
    exp_sym = {^(path & g0), ^(path & g1)};
  endfunction

endpackage

// File: rtl/acs_lane.sv
// One add-compare-select lane: saturating cost for each predecessor,
// strict-less compare (ties keep p0) and reachability handling.
module acs_lane
  import viterbi_pkg::*;
#(
  parameter int PM_W = PM_W_DEF,
  parameter int BM_W = BM_W_DEF
) (
  input  logic [PM_W-1:0] pm0,
  input  logic            v0,
  input  logic [BM_W-1:0] bm0,
  input  logic [PM_W-1:0] pm1,
  input  logic            v1,
  input  logic [BM_W-1:0] bm1,
  output logic [PM_W-1:0] pm_new,
  output logic            v_new,
  output logic            dec
);

  logic [PM_W:0]   cost0_raw, cost1_raw;
  logic [PM_W-1:0] cost0, cost1;

  // One spare bit catches the carry so the sum can clamp at the top value.
  assign cost0_raw = {1'b0, pm0} + (PM_W+1)'(bm0);
  assign cost1_raw = {1'b0, pm1} + (PM_W+1)'(bm1);
  assign cost0     = cost0_raw[PM_W] ? '1 : cost0_raw[PM_W-1:0];
  assign cost1     = cost1_raw[PM_W] ? '1 : cost1_raw[PM_W-1:0];

  // Select the surviving predecessor; an unreachable state reports metric 0.
  always_comb begin
    pm_new = '0;
    v_new  = 1'b0;
    dec    = 1'b0;
    if (v0 && v1) begin
      v_new  = 1'b1;
      dec    = (cost1 < cost0);
      pm_new = (cost1 < cost0) ? cost1 : cost0;
    end else if (v0) begin
      v_new  = 1'b1;
      pm_new = cost0;
    end else if (v1) begin
      v_new  = 1'b1;
      dec    = 1'b1;
      pm_new = cost1;
    end
  end

endmodule

// File: rtl/acs_trellis_unit.sv
// Time-multiplexed Viterbi ACS step: NACS lanes sweep the NSTATES trellis
// states over NSTATES/NACS cycles, ping-ponging path metrics between two banks.
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid never waits on ready, and once raised dec_valid and its
// payload hold until dec_ready accepts them.
module acs_trellis_unit
  import viterbi_pkg::*;
#(
  parameter int             K    = K_DEF,
  parameter int             BM_W = BM_W_DEF,
  parameter int             PM_W = PM_W_DEF,
  parameter int             NACS = NACS_DEF,
  parameter logic [K-1:0]   G0   = G0_DEF,
  parameter logic [K-1:0]   G1   = G1_DEF,
  localparam int            NSTATES = 2**(K-1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                frame_start,
  input  logic                bm_valid,
  output logic                bm_ready,
  input  logic [4*BM_W-1:0]   bm_in,
  output logic                dec_valid,
  input  logic                dec_ready,
  output logic [NSTATES-1:0]  dec_o,
  output logic [NSTATES-1:0]  state_valid_o,
  output logic [K-2:0]        best_state_o,
  output logic [PM_W-1:0]     best_pm_o,
  output logic                norm_o
);

  localparam int SW = K - 1;
  localparam int G  = NSTATES / NACS;
  localparam int GW = (G > 1) ? $clog2(G) : 1;
  localparam logic [PM_W-1:0] HALF = {1'b1, {(PM_W-1){1'b0}}};

  fsm_state_e fsm_state, fsm_next;
  logic [GW-1:0] grp_q;
  logic          last_grp;

  logic [4*BM_W-1:0] bm_r;
  logic              frame_r;
  logic              norm_pend;
  logic              use_norm;

  logic              cur;
  logic              nxt;
  logic [PM_W-1:0]   pm_bank [2][NSTATES];
  logic [NSTATES-1:0] v_bank [2];

  logic [PM_W-1:0]    eff_pm [NSTATES];
  logic [NSTATES-1:0] eff_v;

  logic [PM_W-1:0]    lane_pm [NACS];
  logic [NACS-1:0]    lane_v;
  logic [NACS-1:0]    lane_dec;

  logic [PM_W-1:0]    new_pm [NSTATES];
  logic [NSTATES-1:0] new_v;
  logic [SW-1:0]      best_s;
  logic [PM_W-1:0]    best_pm;
  logic               any_v;

  logic [NSTATES-1:0] dec_q;
  logic [NSTATES-1:0] sv_q;
  logic [SW-1:0]      best_s_q;
  logic [PM_W-1:0]    best_pm_q;
  logic               norm_q;

  assign nxt      = ~cur;
  assign last_grp = (grp_q == GW'(G - 1));
  assign use_norm = norm_pend & ~frame_r;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) fsm_state <= ST_IDLE;
    else        fsm_state <= fsm_next;
  end

  // FSM next state and handshake outputs.
  always_comb begin
    fsm_next  = fsm_state;
    bm_ready  = 1'b0;
    dec_valid = 1'b0;
    case (fsm_state)
      ST_IDLE: begin
        bm_ready = 1'b1;
        if (bm_valid) fsm_next = ST_ACS;
      end
      ST_ACS: begin
        if (last_grp) fsm_next = ST_OUT;
      end
      ST_OUT: begin
        dec_valid = 1'b1;
        if (dec_ready) fsm_next = ST_IDLE;
      end
      default: fsm_next = ST_IDLE;
    endcase
  end

  // Metrics as seen by this step: a frame start forces the initial trellis,
  // otherwise the current bank minus the pending normalisation offset.
  always_comb begin
    eff_v = '0;
    for (int p = 0; p < NSTATES; p++) begin
      if (frame_r) begin
        eff_v[p]  = (p == 0);
        eff_pm[p] = '0;
      end else begin
        eff_v[p]  = v_bank[cur][p];
        eff_pm[p] = pm_bank[cur][p] - (use_norm ? HALF : '0);
      end
    end
  end

  for (genvar l = 0; l < NACS; l++) begin : g_lane
    logic [SW-1:0]   s, p0, p1;
    logic [1:0]      sym0, sym1;
    logic [BM_W-1:0] bm0, bm1;

    // New state handled by this lane; its predecessors differ only in the LSB.
    assign s    = SW'(int'(grp_q) * NACS + l);
    assign p0   = {s[SW-2:0], 1'b0};
    assign p1   = {s[SW-2:0], 1'b1};
    assign sym0 = exp_sym(32'({s[SW-1], p0}), 32'(G0), 32'(G1));
    assign sym1 = exp_sym(32'({s[SW-1], p1}), 32'(G0), 32'(G1));
    assign bm0  = bm_r[int'(sym0)*BM_W +: BM_W];
    assign bm1  = bm_r[int'(sym1)*BM_W +: BM_W];

    acs_lane #(.PM_W(PM_W), .BM_W(BM_W)) u_lane (
      .pm0    (eff_pm[p0]),
      .v0     (eff_v[p0]),
      .bm0    (bm0),
      .pm1    (eff_pm[p1]),
      .v1     (eff_v[p1]),
      .bm1    (bm1),
      .pm_new (lane_pm[l]),
      .v_new  (lane_v[l]),
      .dec    (lane_dec[l])
    );
  end

  // Next-bank view including this cycle's lane results, then lowest-metric
  // scan (strict less keeps the lowest index on ties).
  always_comb begin
    new_v = v_bank[nxt];
    for (int s = 0; s < NSTATES; s++) new_pm[s] = pm_bank[nxt][s];
    if (fsm_state == ST_ACS) begin
      for (int l = 0; l < NACS; l++) begin
        new_pm[int'(grp_q)*NACS + l] = lane_pm[l];
        new_v[int'(grp_q)*NACS + l]  = lane_v[l];
      end
    end
    best_s  = '0;
    best_pm = '0;
    any_v   = 1'b0;
    for (int s = 0; s < NSTATES; s++) begin
      if (new_v[s] && (!any_v || new_pm[s] < best_pm)) begin
        any_v   = 1'b1;
        best_s  = SW'(s);
        best_pm = new_pm[s];
      end
    end
  end

  // Datapath: capture the step, write lane results, swap banks and publish.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      grp_q     <= '0;
      bm_r      <= '0;
      frame_r   <= 1'b0;
      norm_pend <= 1'b0;
      cur       <= 1'b0;
      for (int b = 0; b < 2; b++)
        for (int s = 0; s < NSTATES; s++) pm_bank[b][s] <= '0;
      v_bank[0] <= NSTATES'(1);
      v_bank[1] <= '0;
      dec_q     <= '0;
      sv_q      <= '0;
      best_s_q  <= '0;
      best_pm_q <= '0;
      norm_q    <= 1'b0;
    end else begin
      case (fsm_state)
        ST_IDLE: begin
          if (bm_valid) begin
            bm_r    <= bm_in;
            frame_r <= frame_start;
            grp_q   <= '0;
          end
        end
        ST_ACS: begin
          for (int l = 0; l < NACS; l++) begin
            pm_bank[nxt][int'(grp_q)*NACS + l] <= lane_pm[l];
            v_bank[nxt][int'(grp_q)*NACS + l]  <= lane_v[l];
            dec_q[int'(grp_q)*NACS + l]        <= lane_dec[l];
          end
          if (last_grp) begin
            grp_q     <= '0;
            cur       <= nxt;
            sv_q      <= new_v;
            best_s_q  <= best_s;
            best_pm_q <= best_pm;
            norm_q    <= use_norm;
            norm_pend <= any_v && (best_pm >= HALF);
          end else begin
            grp_q <= grp_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign dec_o         = dec_q;
  assign state_valid_o = sv_q;
  assign best_state_o  = best_s_q;
  assign best_pm_o     = best_pm_q;
  assign norm_o        = norm_q;

endmodule
